// File: rtl/control_unit_pkg.sv
// Shared opcode map, ALU codes, FSM state type and decode result type for the pico-MIPS control unit.
package ctrl_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001001;
  localparam logic [5:0] OP_SUBI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b010010;
  localparam logic [5:0] OP_BNQ  = 6'b011010;
  localparam logic [5:0] OP_JMP  = 6'b100000;
  localparam logic [5:0] OP_MULT = 6'b101011;
  localparam logic [5:0] OP_STIN = 6'b110000;
  localparam logic [5:0] OP_LOUT = 6'b111000;

  // Low ALU_W opcode bits select the ALU function directly
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;

  typedef enum logic [2:0] {
    S_EXEC, S_MUL_WAIT, S_IN_WAIT, S_OUT_WAIT, S_HALT
  } ctrl_state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_ALUI, C_BEQ, C_BNQ, C_JMP, C_MULT, C_STIN, C_LOUT
  } op_class_t;

  typedef struct packed {
    op_class_t cls;
    logic      legal;
  } dec_t;

endpackage

// File: rtl/control_unit_if.sv
// Datapath-facing bundle of the control unit: instruction/flag/IO inputs and decoded strobes.
interface control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALU_W    = 3,
  parameter int CNT_W    = 16
);
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                ZF;
  logic                in_valid;
  logic                out_ready;
  logic [ALU_W-1:0]    alu_func;
  logic                pc_rel_branch;
  logic                pc_stall;
  logic                reg_write;
  logic                immediate;
  logic                mult;
  logic                read_in;
  logic                write_out;
  logic                in_ack;
  logic                illegal_op;
  logic [CNT_W-1:0]    retired_cnt;

  modport master (
    output instr_valid, opcode, ZF, in_valid, out_ready,
    input  alu_func, pc_rel_branch, pc_stall, reg_write, immediate, mult,
           read_in, write_out, in_ack, illegal_op, retired_cnt
  );

  modport slave (
    input  instr_valid, opcode, ZF, in_valid, out_ready,
    output alu_func, pc_rel_branch, pc_stall, reg_write, immediate, mult,
           read_in, write_out, in_ack, illegal_op, retired_cnt
  );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational opcode classifier; anything outside the opcode map is flagged illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output dec_t                dec
);
  always_comb begin
    dec.cls   = C_NOP;
    dec.legal = 1'b1;
    case (opcode)
      OPCODE_W'(OP_NOP):  dec.cls = C_NOP;
      OPCODE_W'(OP_ADD),
      OPCODE_W'(OP_SUB):  dec.cls = C_ALU;
      OPCODE_W'(OP_ADDI),
      OPCODE_W'(OP_SUBI): dec.cls = C_ALUI;
      OPCODE_W'(OP_BEQ):  dec.cls = C_BEQ;
      OPCODE_W'(OP_BNQ):  dec.cls = C_BNQ;
      OPCODE_W'(OP_JMP):  dec.cls = C_JMP;
      OPCODE_W'(OP_MULT): dec.cls = C_MULT;
      OPCODE_W'(OP_STIN): dec.cls = C_STIN;
      OPCODE_W'(OP_LOUT): dec.cls = C_LOUT;
      default:            dec.legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// pico-MIPS control unit: zero-latency strobe decode plus an FSM for multi-cycle MULT,
// handshaked STIN/LOUT and a sticky illegal-opcode halt; counts retired instructions.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_W       = 3,
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.slave bus
);
  localparam int MC_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

  ctrl_state_t      state, next;
  dec_t             dec;
  logic [MC_W-1:0]  mul_cnt;
  logic [CNT_W-1:0] cnt;
  logic             ill;
  logic             rw, imm, br, stall, mul, rin, wout, ack;
  logic             retire, ld_mul, set_ill;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (.opcode(bus.opcode), .dec(dec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_EXEC;
      mul_cnt <= '0;
      cnt     <= '0;
      ill     <= 1'b0;
    end else begin
      state <= next;
      if (ld_mul)                  mul_cnt <= MC_W'(MULT_CYCLES - 1);
      else if (state == S_MUL_WAIT) mul_cnt <= mul_cnt - MC_W'(1);
      if (retire)  cnt <= cnt + CNT_W'(1);
      if (set_ill) ill <= 1'b1;
    end
  end

  always_comb begin
    next    = state;
    rw      = 1'b0;
    imm     = 1'b0;
    br      = 1'b0;
    stall   = 1'b0;
    mul     = 1'b0;
    rin     = 1'b0;
    wout    = 1'b0;
    ack     = 1'b0;
    retire  = 1'b0;
    ld_mul  = 1'b0;
    set_ill = 1'b0;
    if (!rst) begin
      case (state)
        S_EXEC: begin
          if (bus.instr_valid) begin
            if (!dec.legal) begin
              // Stall immediately so the PC never moves past the offending word
              set_ill = 1'b1;
              stall   = 1'b1;
              next    = S_HALT;
            end else begin
              case (dec.cls)
                C_ALU:  begin rw = 1'b1; retire = 1'b1; end
                C_ALUI: begin rw = 1'b1; imm = 1'b1; retire = 1'b1; end
                C_BEQ:  begin br = bus.ZF;  retire = 1'b1; end
                C_BNQ:  begin br = ~bus.ZF; retire = 1'b1; end
                C_JMP:  begin br = 1'b1;    retire = 1'b1; end
                C_MULT: begin
                  mul = 1'b1;
                  if (MULT_CYCLES == 1) begin
                    rw     = 1'b1;
                    retire = 1'b1;
                  end else begin
                    stall  = 1'b1;
                    ld_mul = 1'b1;
                    next   = S_MUL_WAIT;
                  end
                end
                C_STIN: begin
                  rin = 1'b1;
                  if (bus.in_valid) begin
                    rw = 1'b1; ack = 1'b1; retire = 1'b1;
                  end else begin
                    stall = 1'b1; next = S_IN_WAIT;
                  end
                end
                C_LOUT: begin
                  wout = 1'b1;
                  if (bus.out_ready) retire = 1'b1;
                  else begin stall = 1'b1; next = S_OUT_WAIT; end
                end
                default: retire = 1'b1;
              endcase
            end
          end
        end
        S_MUL_WAIT: begin
          mul = 1'b1;
          if (mul_cnt == MC_W'(1)) begin
            rw = 1'b1; retire = 1'b1; next = S_EXEC;
          end else stall = 1'b1;
        end
        S_IN_WAIT: begin
          rin = 1'b1;
          if (bus.in_valid) begin
            rw = 1'b1; ack = 1'b1; retire = 1'b1; next = S_EXEC;
          end else stall = 1'b1;
        end
        S_OUT_WAIT: begin
          wout = 1'b1;
          if (bus.out_ready) begin retire = 1'b1; next = S_EXEC; end
          else stall = 1'b1;
        end
        S_HALT:  stall = 1'b1;
        default: next = S_EXEC;
      endcase
    end
  end

  assign bus.alu_func      = bus.opcode[ALU_W-1:0];
  assign bus.reg_write     = rw;
  assign bus.immediate     = imm;
  assign bus.pc_rel_branch = br;
  assign bus.pc_stall      = stall;
  assign bus.mult          = mul;
  assign bus.read_in       = rin;
  assign bus.write_out     = wout;
  assign bus.in_ack        = ack;
  assign bus.illegal_op    = ill;
  assign bus.retired_cnt   = cnt;
endmodule

// File: tb/tb_control_unit.sv
// Drives two control units (MULT_CYCLES=4/CNT_W=16 and MULT_CYCLES=1/CNT_W=2) with directed
// and random instruction streams, comparing against an instruction-level reference model.
module tb_control_unit;
  import ctrl_pkg::*;

  logic       clk, rst;
  logic       iv, zf, inv, ordy;
  logic [5:0] opcode;
  int         checks = 0;
  int         errors = 0;

  localparam logic [5:0] LEGAL [11] = '{OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_BEQ,
                                        OP_BNQ, OP_JMP, OP_MULT, OP_STIN, OP_LOUT};

  control_unit_if #(.OPCODE_W(6), .ALU_W(3), .CNT_W(16)) cu_a ();
  control_unit_if #(.OPCODE_W(6), .ALU_W(3), .CNT_W(2))  cu_b ();

  assign cu_a.instr_valid = iv;   assign cu_b.instr_valid = iv;
  assign cu_a.opcode      = opcode; assign cu_b.opcode    = opcode;
  assign cu_a.ZF          = zf;   assign cu_b.ZF          = zf;
  assign cu_a.in_valid    = inv;  assign cu_b.in_valid    = inv;
  assign cu_a.out_ready   = ordy; assign cu_b.out_ready   = ordy;

  control_unit #(.OPCODE_W(6), .ALU_W(3), .MULT_CYCLES(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(cu_a));
  control_unit #(.OPCODE_W(6), .ALU_W(3), .MULT_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(cu_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: an in-flight multi-cycle op and how many cycles it has run
  typedef struct {
    bit       halt;
    bit       busy;
    bit [5:0] bop;
    int       el;
    int       cnt;
  } mdl_t;

  mdl_t ma, mb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // e = {reg_write, immediate, pc_rel_branch, pc_stall, mult, read_in, write_out, in_ack, illegal_op}
  task automatic ref_step(inout mdl_t m, input int mc, input int cw,
                          output logic [8:0] e, output int cnt_pre);
    bit rw, imm, br, stall, mul, rin, wout, ack, ill, ret;
    int k;
    {rw, imm, br, stall, mul, rin, wout, ack, ill, ret} = '0;
    if (rst) begin
      m = '{halt: 0, busy: 0, bop: 0, el: 0, cnt: 0};
      e = '0;
      cnt_pre = 0;
      return;
    end
    ill     = m.halt;
    cnt_pre = m.cnt;
    if (m.halt) stall = 1;
    else begin
      if (!m.busy && iv) begin
        case (opcode)
          OP_ADD, OP_SUB:   begin rw = 1; ret = 1; end
          OP_ADDI, OP_SUBI: begin rw = 1; imm = 1; ret = 1; end
          OP_BEQ:           begin br = zf;  ret = 1; end
          OP_BNQ:           begin br = !zf; ret = 1; end
          OP_JMP:           begin br = 1;   ret = 1; end
          OP_NOP:           ret = 1;
          OP_MULT, OP_STIN, OP_LOUT: begin m.busy = 1; m.bop = opcode; m.el = 0; end
          default:          begin m.halt = 1; stall = 1; end
        endcase
      end
      if (m.busy) begin
        k = m.el + 1;
        m.el = k;
        case (m.bop)
          OP_MULT: begin
            mul = 1;
            if (k >= mc) begin rw = 1; ret = 1; m.busy = 0; end else stall = 1;
          end
          OP_STIN: begin
            rin = 1;
            if (inv) begin rw = 1; ack = 1; ret = 1; m.busy = 0; end else stall = 1;
          end
          default: begin
            wout = 1;
            if (ordy) begin ret = 1; m.busy = 0; end else stall = 1;
          end
        endcase
      end
    end
    if (ret) m.cnt = (m.cnt + 1) % (1 << cw);
    e = {rw, imm, br, stall, mul, rin, wout, ack, ill};
  endtask

  task automatic step();
    logic [8:0] ea, eb;
    int ca, cb;
    #1;
    ref_step(ma, 4, 16, ea, ca);
    ref_step(mb, 1, 2, eb, cb);
    chk("a_strobes", {cu_a.reg_write, cu_a.immediate, cu_a.pc_rel_branch, cu_a.pc_stall,
                      cu_a.mult, cu_a.read_in, cu_a.write_out, cu_a.in_ack, cu_a.illegal_op}, ea);
    chk("b_strobes", {cu_b.reg_write, cu_b.immediate, cu_b.pc_rel_branch, cu_b.pc_stall,
                      cu_b.mult, cu_b.read_in, cu_b.write_out, cu_b.in_ack, cu_b.illegal_op}, eb);
    chk("a_cnt", cu_a.retired_cnt, ca);
    chk("b_cnt", cu_b.retired_cnt, cb);
    chk("a_alu", cu_a.alu_func, opcode[2:0]);
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit v, input logic [5:0] op,
                       input bit z, input bit i, input bit o);
    rst = r; iv = v; opcode = op; zf = z; inv = i; ordy = o;
    step();
  endtask

  initial begin
    ma = '{halt: 0, busy: 0, bop: 0, el: 0, cnt: 0};
    mb = ma;
    rst = 1; iv = 0; opcode = OP_NOP; zf = 0; inv = 0; ordy = 0;
    @(negedge clk);
    drive(1, 1, OP_ADD, 0, 0, 0);
    chk("rst_stall", cu_a.pc_stall, 0);
    chk("rst_rw", cu_a.reg_write, 0);

    // 1: single-cycle ops
    drive(0, 1, OP_ADD, 1, 0, 0);
    drive(0, 1, OP_ADDI, 1, 0, 0);
    drive(0, 1, OP_BEQ, 1, 0, 0);
    drive(0, 1, OP_BNQ, 1, 0, 0);
    chk("t1_cnt", cu_a.retired_cnt, 4);

    // 2: MULT held for the full latency
    repeat (4) drive(0, 1, OP_MULT, 0, 0, 0);
    chk("t2_cnt", cu_a.retired_cnt, 5);

    // 3: STIN waits for input data
    repeat (3) drive(0, 1, OP_STIN, 0, 0, 0);
    drive(0, 1, OP_STIN, 0, 1, 0);
    drive(0, 0, OP_NOP, 0, 1, 0);

    // 4: LOUT waits for the sink
    repeat (2) drive(0, 1, OP_LOUT, 0, 0, 0);
    drive(0, 1, OP_LOUT, 0, 0, 1);

    // 5: illegal opcode halts until reset
    drive(0, 1, 6'h3f, 0, 0, 0);
    repeat (3) drive(0, 1, OP_ADD, 0, 1, 1);
    chk("t5_ill", cu_a.illegal_op, 1);
    drive(1, 1, OP_ADD, 0, 0, 0);
    chk("t5_clr", cu_a.illegal_op, 0);

    // 6: reset aborts an in-flight MULT; small counter wraps
    drive(0, 1, OP_MULT, 0, 0, 0);
    drive(1, 1, OP_MULT, 0, 0, 0);
    chk("t6_cnt", cu_a.retired_cnt, 0);
    repeat (5) drive(0, 1, OP_NOP, 0, 0, 0);
    chk("t6_wrap", cu_b.retired_cnt, 1);

    // Random stream
    repeat (3000) begin
      logic [5:0] op;
      if ($urandom_range(0, 49) == 0) op = 6'($urandom);
      else op = LEGAL[$urandom_range(0, 10)];
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, op,
            1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
